branch_ctrl: RTL
================

Name: branch_ctrl

Overview:
- Producer side of the program counter's jump interface: decodes the fetched instruction and drives jump enable, jump target and opcode into the PC.
- Holds the branch condition flag written by ALU compare operations.
- Runs a small IDLE/RUN/DONE sequencer, raises done on halt or end-of-program, and counts taken jumps for testbench and debug visibility.
- Sits between instruction memory/decoder and the PC.

Parameters:
- D, 10, program counter and target width in bits.
- IW, 9, instruction word width; opcode in bits [IW-1:IW-3], immediate in bits [5:0].
- MAX_PC, 1023, PC value at which the program is considered finished.
- CW, 16, width of taken-jump counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; restarts program (PC zeroes on same edge)
- instr  in  IW  currently fetched instruction
- pc_in  in  D  current programCounter value
- cmp_valid  in  1  ALU compare result valid this cycle
- cmp_result  in  1  ALU compare outcome (1 = condition true)
- jump_en  out  1  to PC jumpEn
- target  out  D  to PC target
- pc_op  out  3  to PC instruction
- done  out  1  program finished, held high
- taken_count  out  CW  number of taken jumps since start

Behaviour:
- Reset, and start, force: state IDLE->RUN on start / IDLE on reset; flag=0; done=0; taken_count=0. Reset has priority over start.
- Outputs in IDLE and DONE: jump_en=0, pc_op=3'b000, target=0.
- FSM:
  - IDLE -> RUN on start.
  - RUN -> DONE on opcode 3'b110 (halt) or when pc_in==MAX_PC.
  - DONE -> RUN on start.
  - start in RUN restarts: stays RUN, clears flag and count.
- Decode in RUN is combinational from instr and the registered flag, with zero latency: outputs are valid in the same cycle as instr.
- Opcode 3'b111, absolute conditional jump:
  - pc_op=3'b111; target = zero-extended imm6; jump_en = flag.
  - Codes 56..63 pass through unchanged; the PC maps them to fixed or relative destinations.
- Opcode 3'b001, relative conditional jump:
  - pc_op=3'b001; target = sign-extended imm6 to D bits; jump_en = flag.
  - The PC adds this modulo 2^D, so a negative immediate branches backward; wrap-around is intended.
- All other opcodes: jump_en=0, target=0, pc_op=opcode.
- Flag register:
  - Loads cmp_result on cmp_valid.
  - Cleared on the edge where a jump is taken (jump_en=1).
  - If cmp_valid and a taken jump coincide, cmp_valid wins and the flag loads cmp_result.
- taken_count increments on each edge with jump_en=1 in RUN, saturates at all-ones and never wraps.
- done:
  - Registered; rises on the edge after the halt or MAX_PC condition is seen.
  - Stays high until start or reset.
  - A halt present in the same cycle as start is ignored, because start dominates.
- No jump is issued in the cycle the halt is decoded.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_JABS=3'b111, OP_JREL=3'b001, OP_HALT=3'b110, OP_NOP=3'b000;
  - state typedef enum {IDLE, RUN, DONE};
  - the special-target code range 56..63.
- One natural sub-module, sat_counter (parameter CW; ports clk, reset, clr, inc, count), used for taken_count.
- The FSM and decode stay in branch_ctrl.

Test Plan:
- Reset, then start; instr=OP_JABS imm=20 with flag=0 -> jump_en=0, pc_op=3'b111, target=20; taken_count=0.
- cmp_valid=1, cmp_result=1, then OP_JABS imm=20 -> jump_en=1, target=20; next cycle flag=0 and taken_count=1.
- Flag=1, OP_JREL imm=6'b111101 (-3), D=10 -> target=10'h3FD, jump_en=1; a PC model at 100 goes to 97.
- Flag=1, OP_JABS imm=63 -> target=63 passed unchanged; cmp_valid=1/cmp_result=1 in the same taken cycle -> flag remains 1.
- Halt at cycle N -> done=1 at N+1, jump_en=0 thereafter; start -> done=0, state RUN, taken_count=0.
- Force 65536 taken jumps with CW=16 -> taken_count holds 16'hFFFF; reset asserted mid-RUN with flag=1 -> next cycle state IDLE, flag=0, outputs zero.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode constants and sequencer state type for the branch controller and PC.
package cpu_pkg;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_JREL = 3'b001;
   localparam logic [2:0] OP_HALT = 3'b110;
   localparam logic [2:0] OP_JABS = 3'b111;

   // Absolute targets in this range are interpreted by the PC, not by this block.
   localparam int SPECIAL_TGT_LO = 56;
   localparam int SPECIAL_TGT_HI = 63;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic is_special_target(input logic [5:0] imm);
      return (int'(imm) >= SPECIAL_TGT_LO) && (int'(imm) <= SPECIAL_TGT_HI);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous reset and clear.
module sat_counter #(
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset || clr)
         count <= '0;
      else if (inc && (count != {CW{1'b1}}))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/branch_ctrl.sv
// Decodes fetched instructions into the PC jump interface, holds the compare flag,
// sequences the program run and counts taken jumps.
//
//   state | meaning
//   IDLE  | after reset, waiting for start; jump interface held at zero
//   RUN   | program executing; decode drives jump_en/target/pc_op
//   DONE  | halt or end-of-program seen; done high until start
module branch_ctrl
   import cpu_pkg::*;
#(
   parameter int D      = 10,
   parameter int IW     = 9,
   parameter int MAX_PC = 1023,
   parameter int CW     = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [IW-1:0] instr,
   input  logic [D-1:0]  pc_in,
   input  logic          cmp_valid,
   input  logic          cmp_result,
   output logic          jump_en,
   output logic [D-1:0]  target,
   output logic [2:0]    pc_op,
   output logic          done,
   output logic [CW-1:0] taken_count
);

   localparam logic [D-1:0] PC_END = D'(MAX_PC);

   state_t      state, state_nxt;
   logic        flag;
   logic [2:0]  opcode;
   logic [5:0]  imm;

   assign opcode = instr[IW-1:IW-3];
   assign imm    = instr[5:0];

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      jump_en   = 1'b0;
      target    = '0;
      pc_op     = OP_NOP;
      case (state)
         RUN: begin
            pc_op = opcode;
            case (opcode)
               OP_JABS: begin
                  target  = {{(D-6){1'b0}}, imm};
                  jump_en = flag;
               end
               OP_JREL: begin
                  // PC adds this modulo 2^D, so negative offsets branch backward
                  target  = {{(D-6){imm[5]}}, imm};
                  jump_en = flag;
               end
               default: ;
            endcase
            if ((opcode == OP_HALT) || (pc_in == PC_END))
               state_nxt = DONE;
         end
         DONE: ;
         IDLE: ;
         default: state_nxt = IDLE;
      endcase
      // start restarts from any state and overrides a halt seen this cycle
      if (start)
         state_nxt = RUN;
   end

   // A new compare result outranks the clear caused by a taken jump.
   always_ff @(posedge clk) begin
      if (reset || start)
         flag <= 1'b0;
      else if (cmp_valid)
         flag <= cmp_result;
      else if (jump_en)
         flag <= 1'b0;
   end

   assign done = (state == DONE);

   sat_counter #(.CW(CW)) u_taken_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (start),
      .inc   (jump_en),
      .count (taken_count)
   );

endmodule
